// File: rtl/fft_pkg.sv
// Shared FFT datapath constants and a scalar round/saturate helper for later stages.
package fft_pkg;

  localparam int unsigned LANES         = 16;
  localparam int unsigned BLK_PER_FRAME = 4;
  localparam int unsigned TW_FRAC       = 7;

  // Round-half-up by 'shift' LSBs, then clamp to a signed 'width'-bit range.
  function automatic longint round_sat(input longint value, input int unsigned shift,
                                       input int unsigned width);
    longint r;
    longint hi;
    longint lo;
    r  = (value + (longint'(1) <<< (shift - 1))) >>> shift;
    hi = (longint'(1) <<< (width - 1)) - 1;
    lo = -(longint'(1) <<< (width - 1));
    if (r > hi) return hi;
    if (r < lo) return lo;
    return r;
  endfunction

endpackage

// File: rtl/round_sat_m1_if.sv
// Lane-vector bus between the twiddle multiplier, this stage and the next butterfly.
interface round_sat_m1_if
  import fft_pkg::*;
#(
  parameter int unsigned I_WIDTH    = 24,
  parameter int unsigned O_WIDTH    = 16,
  parameter int unsigned DATA_WIDTH = LANES
);

  logic                                  din_valid;
  logic [DATA_WIDTH-1:0][I_WIDTH-1:0]    din_re;
  logic [DATA_WIDTH-1:0][I_WIDTH-1:0]    din_im;
  logic                                  clr_ovf;
  logic                                  dout_valid;
  logic [DATA_WIDTH-1:0][O_WIDTH-1:0]    dout_re;
  logic [DATA_WIDTH-1:0][O_WIDTH-1:0]    dout_im;
  logic [1:0]                            dout_count;
  logic                                  dout_sop;
  logic                                  sat_now;
  logic                                  ovf_sticky;

  modport master (
    output din_valid, din_re, din_im, clr_ovf,
    input  dout_valid, dout_re, dout_im, dout_count, dout_sop, sat_now, ovf_sticky
  );

  modport slave (
    input  din_valid, din_re, din_im, clr_ovf,
    output dout_valid, dout_re, dout_im, dout_count, dout_sop, sat_now, ovf_sticky
  );

endinterface

// File: rtl/round_sat_m1_lane.sv
// One lane value: stage-1 rounding register, stage-2 saturation register and overflow flag.
module round_sat_lane #(
  parameter int unsigned I_WIDTH = 24,
  parameter int unsigned O_WIDTH = 16,
  parameter int unsigned SHIFT   = 7
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               ld1,
  input  logic               ld2,
  input  logic [I_WIDTH-1:0] din,
  output logic [O_WIDTH-1:0] dout,
  output logic               sat_c
);

  // One extra bit above the shifted width so the rounding add never wraps.
  localparam int unsigned R_WIDTH = I_WIDTH - SHIFT + 1;
  localparam int unsigned H_WIDTH = R_WIDTH - O_WIDTH + 1;

  logic signed [I_WIDTH:0] sum_c;
  logic [R_WIDTH-1:0]      rnd_c;
  logic [R_WIDTH-1:0]      r_q;
  logic [H_WIDTH-1:0]      hi_c;
  logic [O_WIDTH-1:0]      sat_val_c;

  assign sum_c = $signed({din[I_WIDTH-1], din}) + $signed((I_WIDTH+1)'(1 << (SHIFT - 1)));
  assign rnd_c = R_WIDTH'(sum_c >>> SHIFT);

  // Value fits only if every bit from the output sign upward agrees.
  assign hi_c      = r_q[R_WIDTH-1:O_WIDTH-1];
  assign sat_c     = ~((&hi_c) | ~(|hi_c));
  assign sat_val_c = sat_c ? {r_q[R_WIDTH-1], {(O_WIDTH-1){~r_q[R_WIDTH-1]}}}
                           : r_q[O_WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_q <= '0;
    end else if (ld1) begin
      r_q <= rnd_c;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      dout <= '0;
    end else if (ld2) begin
      dout <= sat_val_c;
    end
  end

endmodule

// File: rtl/round_sat_m1.sv
// Post-twiddle round/saturate stage: lane array plus valid pipe, block counter and overflow flags.
module round_sat_m1
  import fft_pkg::*;
#(
  parameter int unsigned I_WIDTH    = 24,
  parameter int unsigned O_WIDTH    = 16,
  parameter int unsigned SHIFT      = TW_FRAC,
  parameter int unsigned DATA_WIDTH = LANES
) (
  input logic           clk,
  input logic           rstn,
  round_sat_m1_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(BLK_PER_FRAME);
  localparam int unsigned N_VAL = 2 * DATA_WIDTH;

  logic                               v1_q;
  logic                               dv_q;
  logic [CNT_W-1:0]                   cnt_q;
  logic [CNT_W-1:0]                   count_q;
  logic                               sop_q;
  logic                               sat_q;
  logic                               ovf_q;
  logic [N_VAL-1:0]                   sat_c;
  logic [DATA_WIDTH-1:0][O_WIDTH-1:0] re_q;
  logic [DATA_WIDTH-1:0][O_WIDTH-1:0] im_q;

  for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_lane
    round_sat_lane #(.I_WIDTH(I_WIDTH), .O_WIDTH(O_WIDTH), .SHIFT(SHIFT)) u_re (
      .clk  (clk),
      .rstn (rstn),
      .ld1  (bus.din_valid),
      .ld2  (v1_q),
      .din  (bus.din_re[i]),
      .dout (re_q[i]),
      .sat_c(sat_c[2*i])
    );
    round_sat_lane #(.I_WIDTH(I_WIDTH), .O_WIDTH(O_WIDTH), .SHIFT(SHIFT)) u_im (
      .clk  (clk),
      .rstn (rstn),
      .ld1  (bus.din_valid),
      .ld2  (v1_q),
      .din  (bus.din_im[i]),
      .dout (im_q[i]),
      .sat_c(sat_c[2*i+1])
    );
  end

  // Valid pipe, block index and per-vector flags, all aligned with dout_valid.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      v1_q    <= 1'b0;
      dv_q    <= 1'b0;
      cnt_q   <= '0;
      count_q <= '0;
      sop_q   <= 1'b0;
      sat_q   <= 1'b0;
    end else begin
      v1_q  <= bus.din_valid;
      dv_q  <= v1_q;
      sop_q <= v1_q & (cnt_q == '0);
      sat_q <= v1_q & (|sat_c);
      if (v1_q) begin
        count_q <= cnt_q;
        cnt_q   <= cnt_q + CNT_W'(1);
      end
    end
  end

  // Sticky overflow: a saturating output beats a simultaneous clear.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      ovf_q <= 1'b0;
    end else if (dv_q & sat_q) begin
      ovf_q <= 1'b1;
    end else if (bus.clr_ovf) begin
      ovf_q <= 1'b0;
    end
  end

  assign bus.dout_valid = dv_q;
  assign bus.dout_re    = re_q;
  assign bus.dout_im    = im_q;
  assign bus.dout_count = count_q;
  assign bus.dout_sop   = sop_q;
  assign bus.sat_now    = sat_q;
  assign bus.ovf_sticky = ovf_q;

endmodule

// File: tb/tb_round_sat_m1.sv
// Self-checking bench for round_sat_m1: directed scenarios plus randomized traffic vs a cycle-level model.
module tb_round_sat_m1;

  localparam int unsigned IW = 24;
  localparam int unsigned OW = 16;
  localparam int unsigned SH = 7;
  localparam int unsigned DW = 16;
  localparam int O_MAX = 32767;
  localparam int O_MIN = -32768;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  round_sat_m1_if #(.I_WIDTH(IW), .O_WIDTH(OW), .DATA_WIDTH(DW)) bus ();

  round_sat_m1 #(.I_WIDTH(IW), .O_WIDTH(OW), .SHIFT(SH), .DATA_WIDTH(DW)) dut (
    .clk (clk),
    .rstn(rstn),
    .bus (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  // stimulus currently driven
  int in_re[DW];
  int in_im[DW];

  // reference model state
  bit  pend_v = 1'b0;
  int  pend_re[DW];
  int  pend_im[DW];
  int  blk = 0;
  bit  e_valid = 1'b0, e_sop = 1'b0, e_sat = 1'b0, e_ovf = 1'b0;
  int  e_cnt = 0;
  logic [DW-1:0][OW-1:0] e_re = '0, e_im = '0;

  // bookkeeping
  bit cap_en = 1'b0;
  int cap_q[$];
  bit cnt_en = 1'b0;
  int obs_out = 0;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Real-valued round-half-up: floor(x/128 + 1/2).
  function automatic int ref_round(input int x);
    return $rtoi($floor((real'(x) + real'(1 << (SH - 1))) / real'(1 << SH)));
  endfunction

  function automatic int clamp(input int r);
    if (r > O_MAX) return O_MAX;
    if (r < O_MIN) return O_MIN;
    return r;
  endfunction

  task automatic drive(input bit v, input bit clr);
    bus.din_valid = v;
    bus.clr_ovf   = clr;
    for (int i = 0; i < DW; i++) begin
      bus.din_re[i] = IW'(in_re[i]);
      bus.din_im[i] = IW'(in_im[i]);
    end
  endtask

  task automatic zero_data();
    for (int i = 0; i < DW; i++) begin
      in_re[i] = 0;
      in_im[i] = 0;
    end
  endtask

  task automatic rand_data();
    for (int i = 0; i < DW; i++) begin
      logic [23:0] t;
      int mode;
      mode = int'($urandom_range(0, 3));
      t = 24'($urandom);
      in_re[i] = (mode == 0) ? int'($signed(t)) : int'($signed(t)) >>> (mode + 1);
      t = 24'($urandom);
      in_im[i] = (mode == 3) ? int'($signed(t)) : int'($signed(t)) >>> (mode + 1);
    end
  endtask

  // Advance one clock, update the model from the inputs seen at that edge, compare all outputs.
  task automatic tick();
    bit c_v, c_rstn, c_clr, p_valid, p_sat;
    int c_re[DW];
    int c_im[DW];
    c_v    = bus.din_valid;
    c_rstn = rstn;
    c_clr  = bus.clr_ovf;
    for (int i = 0; i < DW; i++) begin
      c_re[i] = in_re[i];
      c_im[i] = in_im[i];
    end
    @(posedge clk);
    #1;
    p_valid = e_valid;
    p_sat   = e_sat;
    if (!c_rstn) begin
      e_valid = 1'b0; e_sop = 1'b0; e_sat = 1'b0; e_ovf = 1'b0;
      e_cnt = 0; blk = 0; e_re = '0; e_im = '0; pend_v = 1'b0;
    end else begin
      if (p_valid && p_sat) e_ovf = 1'b1;
      else if (c_clr)       e_ovf = 1'b0;
      if (pend_v) begin
        e_valid = 1'b1;
        e_sat   = 1'b0;
        for (int i = 0; i < DW; i++) begin
          int rr, ri;
          rr = ref_round(pend_re[i]);
          ri = ref_round(pend_im[i]);
          if (clamp(rr) != rr || clamp(ri) != ri) e_sat = 1'b1;
          e_re[i] = OW'(clamp(rr));
          e_im[i] = OW'(clamp(ri));
        end
        e_cnt = blk;
        e_sop = (blk == 0);
        blk   = (blk + 1) % 4;
      end else begin
        e_valid = 1'b0;
        e_sop   = 1'b0;
        e_sat   = 1'b0;
      end
      pend_v = c_v;
      for (int i = 0; i < DW; i++) begin
        pend_re[i] = c_re[i];
        pend_im[i] = c_im[i];
      end
    end
    check("dout_valid", 256'(bus.dout_valid), 256'(e_valid));
    check("dout_re",    256'(bus.dout_re),    256'(e_re));
    check("dout_im",    256'(bus.dout_im),    256'(e_im));
    check("dout_count", 256'(bus.dout_count), 256'(e_cnt));
    check("dout_sop",   256'(bus.dout_sop),   256'(e_sop));
    check("sat_now",    256'(bus.sat_now),    256'(e_sat));
    check("ovf_sticky", 256'(bus.ovf_sticky), 256'(e_ovf));
    if (bus.dout_valid === 1'b1) begin
      if (cap_en) cap_q.push_back(int'($signed(bus.dout_re[0])));
      if (cnt_en) obs_out++;
    end
  endtask

  task automatic idle(input int n);
    zero_data();
    drive(1'b0, 1'b0);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic send_lane0(input int v);
    zero_data();
    in_re[0] = v;
    drive(1'b1, 1'b0);
    tick();
  endtask

  initial begin
    int exp_r[5];
    int rnd_in;
    exp_r = '{1, 0, 0, -1, 1};

    // reset
    zero_data();
    drive(1'b0, 1'b0);
    rstn = 1'b0;
    tick();
    tick();
    rstn = 1'b1;
    idle(2);

    // rounding, ties toward +inf
    cap_en = 1'b1;
    send_lane0(64);
    send_lane0(63);
    send_lane0(-64);
    send_lane0(-65);
    send_lane0(191);
    idle(3);
    cap_en = 1'b0;
    check("round_count", 256'(cap_q.size()), 256'(5));
    for (int k = 0; k < 5 && k < cap_q.size(); k++)
      check("round_lane0", 256'(cap_q[k]), 256'(exp_r[k]));

    // saturation both ways, then sticky set / clear priority
    send_lane0(1 << 22);
    send_lane0(-(1 << 23));
    idle(3);
    send_lane0(1 << 22);
    idle(1);
    zero_data();
    drive(1'b0, 1'b1);
    tick();
    tick();
    idle(2);

    // counter: fresh start, 9 back-to-back vectors
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    for (int k = 0; k < 9; k++) begin
      rand_data();
      drive(1'b1, 1'b0);
      tick();
    end
    idle(3);

    // counter: gap of 3 cycles after vector 2
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    for (int k = 0; k < 2; k++) begin
      rand_data();
      drive(1'b1, 1'b0);
      tick();
    end
    idle(3);
    rand_data();
    drive(1'b1, 1'b0);
    tick();
    idle(3);

    // reset mid-frame with vectors in flight; the vector at the reset edge is dropped
    for (int k = 0; k < 2; k++) begin
      rand_data();
      drive(1'b1, 1'b0);
      tick();
    end
    rand_data();
    drive(1'b1, 1'b0);
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    idle(2);
    rand_data();
    drive(1'b1, 1'b0);
    tick();
    idle(3);

    // randomized traffic with gaps and occasional clears
    cnt_en  = 1'b1;
    obs_out = 0;
    rnd_in  = 0;
    for (int v = 0; v < 200; v++) begin
      if ($urandom_range(0, 3) == 0) begin
        int gap;
        gap = int'($urandom_range(1, 3));
        zero_data();
        drive(1'b0, $urandom_range(0, 7) == 0);
        for (int g = 0; g < gap; g++) tick();
      end
      rand_data();
      drive(1'b1, $urandom_range(0, 7) == 0);
      tick();
      rnd_in++;
    end
    idle(4);
    cnt_en = 1'b0;
    check("out_vs_in", 256'(obs_out), 256'(rnd_in));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/round_sat_m1.md
# round_sat_m1

Post-twiddle rounding and saturation stage for the 16-lane parallel FFT datapath. It consumes the 24-bit complex products from the stage-m1 twiddle multiplier and rescales them to 16-bit lanes for the next butterfly stage. It also provides three things the multiplier lacks: valid tracking through its own pipeline, a block counter that regenerates the 2-bit block index, and saturation reporting.

## Interface
Parameters:
- I_WIDTH, 24, signed width of each input lane (twiddle-product width).
- O_WIDTH, 16, signed width of each output lane.
- SHIFT, 7, LSBs dropped by rounding; matches the Q1.7 twiddle scale, where 128 = 1.0.
- DATA_WIDTH, 16, number of parallel lanes.

Ports:
- clk, input, 1, the single clock; all state updates on its rising edge.
- rstn, input, 1, reset; synchronous, active-low.
- din_valid, input, 1, din_re/din_im hold a valid lane vector this cycle.
- din_re, input, I_WIDTH x DATA_WIDTH, signed real products.
- din_im, input, I_WIDTH x DATA_WIDTH, signed imaginary products.
- clr_ovf, input, 1, clears ovf_sticky.
- dout_valid, output, 1, dout_* are valid.
- dout_re, output, O_WIDTH x DATA_WIDTH, rounded and saturated real lanes.
- dout_im, output, O_WIDTH x DATA_WIDTH, rounded and saturated imaginary lanes.
- dout_count, output, 2, block index (0..3) of the current output vector.
- dout_sop, output, 1, high with the first output block of a 64-point frame.
- sat_now, output, 1, at least one lane of the current output vector saturated.
- ovf_sticky, output, 1, a saturation has occurred since the last clear or reset.

## Operation
- Stage 1, rounding, per lane, real and imaginary independently:
  - r = (x + 2^(SHIFT-1)) >>> SHIFT.
  - Arithmetic shift; round-half-up, so ties go toward +inf.
  - r is computed at I_WIDTH-SHIFT+1 bits so the add cannot wrap.
- Stage 2, saturation, per lane:
  - r > 2^(O_WIDTH-1)-1 gives 2^(O_WIDTH-1)-1.
  - r < -2^(O_WIDTH-1) gives -2^(O_WIDTH-1).
  - Otherwise r is truncated to O_WIDTH bits.
  - A per-lane saturation flag is produced; these are ORed across all 32 values into sat_now.
- Valid pipeline:
  - din_valid is delayed two cycles and becomes dout_valid.
  - Data registers load only when the corresponding stage valid is high; otherwise they hold.
- Block counter:
  - 2-bit counter, advanced on each cycle with dout_valid=1.
  - dout_count shows the counter value for the current output; it wraps 3→0.
  - dout_sop = dout_valid & (dout_count==0).
  - Gaps in din_valid do not advance the counter.
- Sticky overflow:
  - ovf_sticky is set by dout_valid & sat_now.
  - It is cleared by clr_ovf.
  - If both happen in the same cycle, set wins.
- Reset, whenever rstn=0 at a clock edge:
  - All pipeline valids are cleared.
  - Counter = 0; ovf_sticky = 0.
  - Data registers = 0.
  - Reset asserted mid-frame discards in-flight vectors, and the next output is block 0.

## Timing
- Latency is exactly 2 cycles: din_valid at cycle N gives dout_valid at cycle N+2. Full throughput is one vector per cycle with no bubbles.
- Reset values of all outputs are 0:
  - dout_valid=0, dout_re/dout_im=0
  - dout_count=0, dout_sop=0
  - sat_now=0, ovf_sticky=0
- sat_now and dout_sop are registered, aligned with dout_valid, and 0 when dout_valid=0.
- dout_count holds its last value when dout_valid=0.
- ovf_sticky updates one cycle after the output cycle that saturated.
- An input vector accepted on the same edge where rstn=0 is dropped.

## Structure
- Shared package fft_pkg holds:
  - the constants LANES=16, BLK_PER_FRAME=4, TW_FRAC=7;
  - a function round_sat(value, shift, width) for reuse by later stages.
- The natural sub-module is round_sat_lane: one lane, both stage registers, and its saturation flag, instantiated DATA_WIDTH×2 times.
- The top level owns the valid pipe, the counter, the sticky flag and the OR-reduction.

## Test plan
- Rounding, lane 0 real inputs 64, 63, -64, -65, 191 → outputs 1, 0, 0, -1, 1, with sat_now=0 on every vector.
- Saturation: 2^22 → 32767 with sat_now=1; -2^23 → -32768 with sat_now=1. ovf_sticky goes high one cycle later and stays high until clr_ovf.
- Clear priority: clr_ovf asserted on the same cycle as a new saturation event → ovf_sticky remains 1. clr_ovf alone → ovf_sticky 0 next cycle.
- Counter: 9 back-to-back valid vectors → dout_count 0,1,2,3,0,1,2,3,0, with dout_sop on vectors 1, 5 and 9. With a 3-cycle din_valid gap after vector 2, vector 3 still has count 2.
- Latency and throughput: random 200 vectors with random valid gaps → each output equals the reference-model rounding of the input from 2 valid-cycles earlier, and the number of outputs equals the number of inputs.
- Reset mid-frame: assert rstn=0 for 1 cycle after vector 2 of a frame → all outputs 0 next cycle, in-flight vectors are not emitted, and the next output has dout_count=0 and dout_sop=1.
